// File: rtl/stereo_frame_fifo.sv
// Stereo frame FIFO: captures one {left,right} pair per LRCK rise, first-word fall-through valid/ready output.
// Optional peak meter built when PEAK_METER_EN is defined.
module stereo_frame_fifo #(
   parameter  int DATA_W = 24,
   parameter  int DEPTH  = 8,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              SCK,
   input  logic              reset_n,
   input  logic              lrck,
   input  logic [DATA_W-1:0] left_in,
   input  logic [DATA_W-1:0] right_in,
   input  logic              out_ready,
   input  logic              clear_ovf,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_left,
   output logic [DATA_W-1:0] out_right,
   output logic [ADDR_W:0]   fill_level,
`ifdef PEAK_METER_EN
   output logic [DATA_W-1:0] peak_left,
   output logic [DATA_W-1:0] peak_right,
   input  logic              peak_clear,
`endif
   output logic              overflow
);

   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

   logic                  lrck_q;
   logic                  cap, full, pop, push;
   logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]       count_q, count_d;
   logic                  ovf_q, ovf_d;
   logic [2*DATA_W-1:0]   head_q, head_d;
   logic [2*DATA_W-1:0]   mem_q [DEPTH];

   assign cap  = lrck & ~lrck_q;
   assign full = (count_q == FULL_CNT);
   assign pop  = (count_q != '0) & out_ready;
   // A pop in the same cycle frees the slot, so a full FIFO can still take the frame.
   assign push = cap & (~full | pop);

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;

      // Head is registered from the next-state view so the output never reads storage combinationally.
      head_d = head_q;
      if (count_d != '0) begin
         if (push && ((count_q == '0) || (count_q == 1 && pop)))
            head_d = {left_in, right_in};
         else
            head_d = mem_q[rd_ptr_d];
      end

      ovf_d = ovf_q;
      if (clear_ovf)          ovf_d = 1'b0;
      if (cap && full && !pop) ovf_d = 1'b1;
   end

   always_ff @(posedge SCK or negedge reset_n) begin
      if (!reset_n) begin
         lrck_q   <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         head_q   <= '0;
      end else begin
         lrck_q   <= lrck;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         head_q   <= head_d;
      end
   end

   always_ff @(posedge SCK) begin
      if (push) mem_q[wr_ptr_q] <= {left_in, right_in};
   end

   assign out_valid  = (count_q != '0);
   assign out_left   = head_q[2*DATA_W-1:DATA_W];
   assign out_right  = head_q[DATA_W-1:0];
   assign fill_level = count_q;
   assign overflow   = ovf_q;

`ifdef PEAK_METER_EN
   logic [DATA_W-1:0] peak_l_q, peak_l_d, peak_r_q, peak_r_d;
   logic [DATA_W-1:0] mag_l, mag_r;

   // Most negative value has no positive twin; clamp it to the largest positive.
   function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x);
      if (!x[DATA_W-1])                          return x;
      else if (x == {1'b1, {(DATA_W-1){1'b0}}})  return {1'b0, {(DATA_W-1){1'b1}}};
      else                                       return -x;
   endfunction

   assign mag_l = mag(left_in);
   assign mag_r = mag(right_in);

   always_comb begin
      peak_l_d = peak_clear ? '0 : peak_l_q;
      peak_r_d = peak_clear ? '0 : peak_r_q;
      if (cap) begin
         if (mag_l > peak_l_d) peak_l_d = mag_l;
         if (mag_r > peak_r_d) peak_r_d = mag_r;
      end
   end

   always_ff @(posedge SCK or negedge reset_n) begin
      if (!reset_n) begin
         peak_l_q <= '0;
         peak_r_q <= '0;
      end else begin
         peak_l_q <= peak_l_d;
         peak_r_q <= peak_r_d;
      end
   end

   assign peak_left  = peak_l_q;
   assign peak_right = peak_r_q;
`endif

endmodule
